// File: rtl/sll_shifter.sv
// sll_shifter: 32-bit logical left barrel shifter, five cascaded 2:1 mux rows.
// Define SLL_OUT_REG_EN for a registered output (async reset, 1-cycle latency).
`default_nettype none

module sll_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic [4:0]  select,
  output logic [31:0] out
);

  // stage[0] is the operand; stage[j+1] is stage[j] shifted by 2^j when select[j] is set.
  logic [5:0][31:0] stage;

  assign stage[0] = in;

  for (genvar j = 0; j < 5; j++) begin : g_stage
    for (genvar k = 0; k < 32; k++) begin : g_bit
      if (k >= (1 << j)) begin : g_mux
        assign stage[j+1][k] = select[j] ? stage[j][k-(1<<j)] : stage[j][k];
      end else begin : g_zero
        assign stage[j+1][k] = select[j] ? 1'b0 : stage[j][k];
      end
    end
  end

`ifdef SLL_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= 32'h0000_0000;
    end else begin
      out <= stage[5];
    end
  end
`else
  // Clock and reset stay on the port list for a build-independent footprint.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign out            = stage[5];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sll_shifter.sv
// tb_sll_shifter: randomized and directed stimulus against an arithmetic reference,
// with a queued scoreboard; registered-build reset and latency checks under SLL_OUT_REG_EN.
`default_nettype none

module tb_sll_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_d;
  logic [4:0]  sel_d;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] a;
    logic [4:0]  s;
  } item_t;

  item_t exp_q[$];

  sll_shifter dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in_d),
    .select (sel_d),
    .out    (out)
  );

  always #5 clk = ~clk;

  // Reference: multiply by 2**s in 64 bits and keep the low word.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s);
    logic [63:0] p;
    p = {32'h0, a} * (64'h1 << s);
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [4:0] s);
    item_t it;
    @(negedge clk);
    in_d  = a;
    sel_d = s;
    it.exp = model(a, s);
    it.a   = a;
    it.s   = s;
    exp_q.push_back(it);
  endtask

  // Inputs change on negedge; the result is stable (either build) by posedge+2.
  always @(posedge clk) begin : monitor
    item_t it;
    #2;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      check($sformatf("sb in=%h sel=%0d", it.a, it.s), out, it.exp);
    end
  end

  initial begin
    rst   = 1'b1;
    in_d  = 32'h0;
    sel_d = 5'd0;
    repeat (2) @(posedge clk);
`ifdef SLL_OUT_REG_EN
    #1 check("reset_state", out, 32'h0000_0000);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a <= 510; a++)
      for (int s = 0; s <= 6; s++)
        drive(32'(a), 5'(s));

    drive(32'hFFFF_FFFF, 5'd0);
    drive(32'hFFFF_FFFF, 5'd1);
    drive(32'hFFFF_FFFF, 5'd16);
    drive(32'hFFFF_FFFF, 5'd31);
    for (int s = 0; s < 32; s++) drive(32'h0000_0001, 5'(s));
    drive(32'h8000_0001, 5'd1);
    for (int i = 0; i < 500; i++) drive($urandom, 5'($urandom_range(0, 31)));

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    // Directed spot checks against fixed literals, independent of the model.
    @(negedge clk);
    in_d = 32'hFFFF_FFFF; sel_d = 5'd16;
    @(posedge clk); #2 check("lit_ffff_16", out, 32'hFFFF_0000);
    @(negedge clk);
    in_d = 32'h8000_0001; sel_d = 5'd1;
    @(posedge clk); #2 check("lit_discard", out, 32'h0000_0002);

`ifdef SLL_OUT_REG_EN
    @(negedge clk);
    in_d = 32'h1234_5678; sel_d = 5'd4;
    @(posedge clk);
    #1 check("pre_reset", out, 32'h2345_6780);
    #1 rst = 1'b1;
    #1 check("rst_async", out, 32'h0000_0000);
    @(negedge clk);
    #1 check("rst_hold_neg", out, 32'h0000_0000);
    @(posedge clk);
    #1 check("rst_hold_edge", out, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst_release", out, 32'h2345_6780);

    @(negedge clk);
    in_d = 32'hDEAD_BEEF; sel_d = 5'd8;
    @(posedge clk);
    #1 check("lat_first", out, 32'hADBE_EF00);
    #2;
    in_d = 32'h0F0F_0F0F; sel_d = 5'd3;
    #1 check("lat_hold", out, 32'hADBE_EF00);
    @(negedge clk);
    #1 check("lat_hold_neg", out, 32'hADBE_EF00);
    @(posedge clk);
    #1 check("lat_update", out, 32'h7878_7878);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
